// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. The main entry M drives the outputs. The skid entry S catches the
// beat accepted while the stage is being stalled, so in_ready can be registered.
// Also provides a synchronous flush, bubble (NOP) tagging and saturating
// stall/bubble counters.
//
// Handshake: a beat moves across a port at a rising edge exactly when valid
// and ready are both high in the cycle before that edge. A source holds valid
// and its payload until the beat is taken. Ready never depends on valid.
`timescale 1ns/1ps
module pipe_stage_skid #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_nop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_nop,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // EMPTY: M and S invalid. ONE: M valid. FULL: M and S valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic              m_nop_q, m_nop_d, s_nop_q, s_nop_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] w_data;
    logic [CTRL_W-1:0] w_ctrl;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshakes, and the normalised beat that gets written: NOP beats carry
    // no payload and a control value that encodes no write.
    always_comb begin
        accept = in_valid && in_ready_q;
        pop    = (state_q != ST_EMPTY) && out_ready;
        w_data = in_nop ? '0 : in_data;
        w_ctrl = in_nop ? CTRL_RST : in_ctrl;
    end

    // Next-state and entry updates. Flush overrides every transition, but a
    // pop in the flush cycle has already been handed downstream.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        m_nop_d  = m_nop_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        s_nop_d  = s_nop_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_data_d = w_data;
                    m_ctrl_d = w_ctrl;
                    m_nop_d  = in_nop;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    m_data_d = w_data;
                    m_ctrl_d = w_ctrl;
                    m_nop_d  = in_nop;
                end else if (accept) begin
                    s_data_d = w_data;
                    s_ctrl_d = w_ctrl;
                    s_nop_d  = in_nop;
                    state_d  = ST_FULL;
                end else if (pop) begin
                    m_data_d = '0;
                    m_ctrl_d = CTRL_RST;
                    m_nop_d  = 1'b0;
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    m_data_d = s_data_q;
                    m_ctrl_d = s_ctrl_q;
                    m_nop_d  = s_nop_q;
                    s_data_d = '0;
                    s_ctrl_d = CTRL_RST;
                    s_nop_d  = 1'b0;
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) begin
            m_data_d = '0;
            m_ctrl_d = CTRL_RST;
            m_nop_d  = 1'b0;
            s_data_d = '0;
            s_ctrl_d = CTRL_RST;
            s_nop_d  = 1'b0;
            state_d  = ST_EMPTY;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    // Saturating counters: stalled cycles, and NOP beats that survive a flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if ((state_q != ST_EMPTY) && !out_ready && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (accept && in_nop && !flush && (bubble_cnt_q != CNT_MAX))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    // State register. Reset wins over flush and any handshake in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b0;
            m_data_q     <= '0;
            m_ctrl_q     <= CTRL_RST;
            m_nop_q      <= 1'b0;
            s_data_q     <= '0;
            s_ctrl_q     <= CTRL_RST;
            s_nop_q      <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            m_data_q     <= m_data_d;
            m_ctrl_q     <= m_ctrl_d;
            m_nop_q      <= m_nop_d;
            s_data_q     <= s_data_d;
            s_ctrl_q     <= s_ctrl_d;
            s_nop_q      <= s_nop_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        in_ready   = in_ready_q;
        out_valid  = (state_q != ST_EMPTY);
        out_data   = m_data_q;
        out_ctrl   = m_ctrl_q;
        out_nop    = m_nop_q;
        stall_cnt  = stall_cnt_q;
        bubble_cnt = bubble_cnt_q;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
module tb_pipe_stage_skid;

    localparam int                DATA_W   = 32;
    localparam int                CTRL_W   = 16;
    localparam int                CNT_W    = 16;
    localparam logic [CTRL_W-1:0] CTRL_RST = 16'h8000;
    localparam int                SB_W     = 1 + CTRL_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, in_valid, in_ready, in_nop;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic              out_valid, out_ready, out_nop;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    // second instance with narrow counters for saturation
    logic              s_rst, s_flush, s_in_valid, s_in_ready, s_in_nop;
    logic [DATA_W-1:0] s_in_data, s_out_data;
    logic [CTRL_W-1:0] s_in_ctrl, s_out_ctrl;
    logic              s_out_valid, s_out_ready, s_out_nop;
    logic [3:0]        s_stall_cnt, s_bubble_cnt;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl), .in_nop(in_nop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .out_nop(out_nop),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST('0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(s_rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl), .in_nop(s_in_nop),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_nop(s_out_nop),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] sb_e;
    int              exp_bubble = 0;

    // Inputs are driven 1ns after the rising edge, so at the falling edge they
    // show what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            exp_q.delete();
            exp_bubble = 0;
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    check("sb_data", 64'(out_data), 64'(sb_e[DATA_W-1:0]));
                    check("sb_ctrl", 64'(out_ctrl), 64'(sb_e[DATA_W +: CTRL_W]));
                    check("sb_nop",  64'(out_nop),  64'(sb_e[SB_W-1]));
                end
            end
            if (flush === 1'b1) begin
                exp_q.delete();
            end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
                if (in_nop) begin
                    exp_q.push_back({1'b1, CTRL_RST, {DATA_W{1'b0}}});
                    exp_bubble++;
                end else begin
                    exp_q.push_back({1'b0, in_ctrl, in_data});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic n, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        in_nop    = n;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
        s_in_ctrl = '0; s_in_nop = 1'b0; s_out_ready = 1'b0;

        // reset / idle
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_out_ctrl", 64'(out_ctrl), 64'(CTRL_RST));
        check("rel_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rel_bubble_cnt", 64'(bubble_cnt), 64'd0);
        next_cycle();
        @(negedge clk);
        check("rel_in_ready_high", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        next_cycle();

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), 16'h00A5, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (i > 1) check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_ready", 64'(in_ready), 64'd1);
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("stream_tail_valid", 64'(out_valid), 64'd1);
        check("stream_tail_data", 64'(out_data), 64'd8);
        next_cycle();
        @(negedge clk);
        check("stream_done", 64'(out_valid), 64'd0);
        check("stream_stall", 64'(stall_cnt), 64'd0);
        next_cycle();
        check("stream_sb_empty", 64'(exp_q.size()), 64'd0);

        // backpressure / skid
        drive(1'b1, 32'h11, 16'h0011, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h22, 16'h0022, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("skid_ready_before_b", 64'(in_ready), 64'd1);
        check("skid_hold_a0", 64'(out_data), 64'h11);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("skid_full_ready", 64'(in_ready), 64'd0);
            check("skid_hold_a", 64'(out_data), 64'h11);
            next_cycle();
        end
        @(negedge clk);
        check("skid_stall_cnt", 64'(stall_cnt), 64'd4);
        out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("skid_ready_back", 64'(in_ready), 64'd1);
        check("skid_b_head", 64'(out_data), 64'h22);
        next_cycle();
        @(negedge clk);
        check("skid_drained", 64'(out_valid), 64'd0);
        check("skid_stall_kept", 64'(stall_cnt), 64'd4);
        next_cycle();

        // bubble
        drive(1'b1, 32'hDEAD, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("bub_valid", 64'(out_valid), 64'd1);
        check("bub_nop", 64'(out_nop), 64'd1);
        check("bub_data", 64'(out_data), 64'd0);
        check("bub_ctrl", 64'(out_ctrl), 64'(CTRL_RST));
        check("bub_cnt", 64'(bubble_cnt), 64'd1);
        next_cycle();
        @(negedge clk);
        check("bub_gone", 64'(out_valid), 64'd0);
        check("bub_nop_clear", 64'(out_nop), 64'd0);
        next_cycle();

        // flush while FULL with a pop in the same cycle
        drive(1'b1, 32'h33, 16'h0033, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h44, 16'h0044, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h55, 16'h0055, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("fl_full_ready", 64'(in_ready), 64'd0);
        check("fl_head_a", 64'(out_data), 64'h33);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("fl_empty", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_data_clear", 64'(out_data), 64'd0);
        check("fl_bubble_same", 64'(bubble_cnt), 64'd1);
        next_cycle();
        check("fl_sb_empty", 64'(exp_q.size()), 64'd0);

        // flush in ONE while an accepted NOP beat is discarded
        drive(1'b1, 32'h66, 16'h0066, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h77, 16'h0077, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("fl1_accepting", 64'(in_ready), 64'd1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("fl1_empty", 64'(out_valid), 64'd0);
        check("fl1_ready", 64'(in_ready), 64'd1);
        check("fl1_nop_uncounted", 64'(bubble_cnt), 64'd1);
        next_cycle();

        // random traffic through the scoreboard
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), DATA_W'($urandom), CTRL_W'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 31) == 0));
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0 && out_valid == 1'b0) break;
            next_cycle();
        end
        check("rand_drain_sb", 64'(exp_q.size()), 64'd0);
        check("rand_drain_valid", 64'(out_valid), 64'd0);
        check("rand_bubble_total", 64'(bubble_cnt), 64'(exp_bubble));

        // saturation on the CNT_W=4 instance
        s_rst = 1'b0;
        next_cycle();
        next_cycle();
        check("sat_ready", 64'(s_in_ready), 64'd1);
        s_in_valid = 1'b1;
        s_in_data  = 32'h99;
        next_cycle();
        s_in_valid = 1'b0;
        repeat (20) next_cycle();
        check("sat_stall_15", 64'(s_stall_cnt), 64'd15);
        next_cycle();
        check("sat_stall_hold", 64'(s_stall_cnt), 64'd15);
        check("sat_head", 64'(s_out_data), 64'h99);
        s_rst = 1'b1;
        next_cycle();
        check("sat_rst_clear", 64'(s_stall_cnt), 64'd0);
        check("sat_rst_empty", 64'(s_out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the CPU datapath; next generation of the fixed-field execution-stage register.
- Carries a generic payload (DATA_W) and a control field (CTRL_W) between stages.
- Replaces the old enable/hold scheme with a valid/ready handshake and a 2-entry skid buffer, so in_ready is registered.
- Adds sync flush, bubble (NOP) tagging and saturating stall/bubble performance counters.

Parameters:
DATA_W, 32, payload width (operands, pc, immediates)
CTRL_W, 16, control-field width (alu op, mux selects, we flags)
CTRL_RST, 0, control value on an empty stage or a NOP beat (must encode no register/memory write)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  sync flush; clears both entries at the next edge
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat (registered)
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control
in_nop  in  1  accepted beat is a bubble
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_data  out  DATA_W  head payload
out_ctrl  out  CTRL_W  head control
out_nop  out  1  head is a bubble
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
bubble_cnt  out  CNT_W  NOP beats accepted and not flushed, saturating

Behaviour:
- Storage: main entry M (drives out_*) and skid entry S. States: EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
- Accept: in_valid && in_ready. Pop: out_valid && out_ready. out_valid = M.valid.
- in_ready = registered !S.valid after the edge's update. Reset value 0. Rises to 1 at the first edge with rst=0, so it is 0 during the first cycle after rst deasserts.
- Write rule: a NOP beat is stored with data=0, ctrl=CTRL_RST, nop=1. A non-NOP beat stores in_data, in_ctrl, nop=0.
- An invalid M drives out_data=0, out_ctrl=CTRL_RST, out_nop=0. On a pop without a refill, M is cleared to these values.
- EMPTY: accept -> ONE, beat into M.
- ONE:
  - accept && pop -> ONE, new beat into M.
  - accept only -> FULL, beat into S, in_ready falls at that edge.
  - pop only -> EMPTY.
- FULL: in_ready=0, so no accept. Pop -> ONE, S moves to M, S cleared, in_ready rises at that edge.
- Order is strict FIFO. Latency EMPTY->out_valid is 1 cycle. Throughput is 1 beat/cycle when out_ready stays high.
- flush=1 at an edge:
  - M and S become invalid with cleared contents; state -> EMPTY; in_ready becomes 1.
  - A beat handshaken in the same cycle is discarded and does not count in bubble_cnt.
  - A pop in the flush cycle completes normally; downstream owns that beat.
- rst=1 at an edge: all state cleared, in_ready=0, counters=0. Takes priority over flush and handshakes, including mid-transfer. Flush does not clear the counters.
- stall_cnt increments at each edge where out_valid=1 && out_ready=0 && !rst, holding at 2^CNT_W-1.
- bubble_cnt increments on each accepted in_nop=1 beat with flush=0 && !rst, also saturating.
- in_data/in_ctrl/in_nop are don't-care when in_valid=0. Outputs never change combinationally with inputs; all outputs are registered.

Test Plan:
- Reset/idle: hold rst 3 cycles, release. Required: out_valid=0, out_ctrl=CTRL_RST, out_data=0 throughout; in_ready=0 for 1 cycle, then 1; counters=0.
- Streaming: out_ready=1; push data 1..8 back-to-back, ctrl=0x00A5. Required: out_data 1..8 in order, one cycle after each accept, no gaps; stall_cnt=0.
- Backpressure/skid: push A=0x11, B=0x22 with out_ready=0. Required: in_ready drops after B; A held 4 cycles; stall_cnt=4. Raise out_ready: A, then B, with in_ready back to 1 after A pops.
- Bubble: push data 0xDEAD with in_nop=1, ctrl=0xFFFF. Required: out_valid=1, out_nop=1, out_data=0, out_ctrl=CTRL_RST; bubble_cnt=1.
- Flush in FULL: FULL with A,B; assert flush with in_valid=1 (C) and out_ready=1. Required: A popped downstream; B and C dropped; next cycle EMPTY, in_ready=1, bubble_cnt unchanged.
- Saturation: CNT_W=4, stall 20 cycles. Required: stall_cnt=15 and holds; rst returns it to 0.
